voq_requester: RTL
==================

Name: voq_requester

Overview:
- Requester side of the two-level PPE crossbar scheduler. Holds a PPE_WIDTH x PPE_WIDTH matrix of per-(input,output) virtual-output-queue cell counters.
- Drives the flattened Req matrix into the scheduler and consumes the returned Gnt matrix.
- On each accepted grant it decrements the granted VOQ and emits a dequeue command to the datapath.
- Cell arrivals enter through a valid/ready handshake from the ingress classifier.

Parameters:
- PPE_WIDTH, 8, ports per side; matrix is PPE_WIDTH x PPE_WIDTH.
- PPE_LOG_W, 3, clog2(PPE_WIDTH); width of input/output indices.
- CNT_W, 4, width of each VOQ counter; max occupancy 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arr_valid  in  1  arrival cell present.
- arr_ready  out  1  arrival accepted this cycle when arr_valid & arr_ready.
- arr_in  in  PPE_LOG_W  arrival input-port index i.
- arr_out  in  PPE_LOG_W  arrival output-port index j.
- Req  out  PPE_WIDTH*PPE_WIDTH  request matrix; bit i*PPE_WIDTH+j = VOQ(i,j) non-empty.
- Gnt  in  PPE_WIDTH*PPE_WIDTH  grant matrix from scheduler, same bit mapping.
- gnt_valid  in  1  scheduler valid; Gnt sampled only when high.
- deq_valid  out  1  one-cycle dequeue pulse.
- deq_in  out  PPE_LOG_W  dequeued input index.
- deq_out  out  PPE_LOG_W  dequeued output index.
- stale_cnt  out  16  saturating count of grants hitting an empty VOQ.
- err  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous): all counters 0, Req=0, deq_valid=0, deq_in=deq_out=0, stale_cnt=0, err=0. Reset mid-operation discards all queued state immediately.
- arr_ready is combinational: high iff cnt[arr_in][arr_out] != 2^CNT_W-1, or an accepted grant on that same VOQ this cycle. No dependency on arr_valid.
- Grant acceptance: when gnt_valid=1 and Gnt != 0, select the set bit k. Multi-hot handling is defined under Optional Feature. k maps to i=k/PPE_WIDTH, j=k%PPE_WIDTH.
  - If cnt[i][j] != 0: decrement, and next cycle drive deq_valid=1, deq_in=i, deq_out=j (latency 1).
  - If cnt[i][j] == 0 (stale grant caused by the scheduler's request register): no decrement, no deq, stale_cnt += 1, saturating at 0xFFFF.
- gnt_valid=0 or Gnt=0: no action; deq_valid=0 next cycle.
- Simultaneous arrival and accepted grant on the same VOQ: counter unchanged, deq still issued. On different VOQs: both updates apply.
- Counter never wraps. Arrival at max without a same-VOQ grant is refused via arr_ready=0. Decrement is only ever applied when the counter is non-zero.
- Req is registered: Req[bit] <= (cnt_next[i][j] != 0), so Req reflects the cycle's arrival and grant with 1-cycle latency.
  - A VOQ at 1 that is granted drops its Req bit the following cycle.
  - Because the scheduler registers Req internally, one stale grant per drained VOQ is legal and is absorbed as above.
- No FSM beyond the counter matrix. deq_valid is a registered pulse and never asserts for two cycles from one grant.

Optional Feature:
- Macro PROT_CHECK_EN.
- Defined:
  - err sets (sticky until reset) when gnt_valid=1 and Gnt has more than one bit set, or when gnt_valid=0 and Gnt != 0.
  - A multi-hot grant is dropped entirely: no decrement, no deq, stale_cnt unchanged.
- Undefined:
  - err tied 0.
  - A multi-hot grant is resolved to the lowest set bit index and processed normally.
  - Gnt is ignored whenever gnt_valid=0.

Test Plan:
- Reset, then arrivals (2,5) x3 -> Req bit 21 high 1 cycle after first accept; cnt(2,5)=3; all other Req bits 0.
- Gnt=1<<21 with gnt_valid for 3 consecutive cycles -> deq_valid on 3 consecutive cycles with deq_in=2, deq_out=5; Req bit 21 low 1 cycle after the 3rd grant. A 4th grant -> no deq, stale_cnt=1.
- Fill (0,0) to 15 (CNT_W=4) -> arr_ready=0 for (0,0), still 1 for (0,1). Arrival plus grant on (0,0) in the same cycle -> arr_ready=1, cnt stays 15, deq issued.
- Concurrent arrival (7,7) and grant on (1,3) with cnt=1 -> cnt(7,7)=1, cnt(1,3)=0; Req bit 63 set and bit 11 cleared in the same following cycle.
- Gnt=0x3 with gnt_valid -> with PROT_CHECK_EN: err=1, no deq. Without it: deq (0,0), err=0.
- Assert rst_n low mid-stream with counters non-zero -> Req, deq_valid and stale_cnt read 0 immediately (asynchronously); after release, grants produce only stale increments.

Source files
------------

// File: rtl/voq_requester.sv
// VOQ requester: per-(input,output) cell counters drive Req and turn grants into dequeue commands. Optional macro PROT_CHECK_EN.
// Latency: grant -> deq 1 cycle; arrival/grant -> Req 1 cycle. arr_ready is combinational.
// Backpressure: arr_ready drops only when the addressed VOQ is full and not being granted this cycle.
module voq_requester #(
    parameter int PPE_WIDTH = 8,
    parameter int PPE_LOG_W = 3,
    parameter int CNT_W     = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           arr_valid,
    output logic                           arr_ready,
    input  logic [PPE_LOG_W-1:0]           arr_in,
    input  logic [PPE_LOG_W-1:0]           arr_out,
    output logic [PPE_WIDTH*PPE_WIDTH-1:0] Req,
    input  logic [PPE_WIDTH*PPE_WIDTH-1:0] Gnt,
    input  logic                           gnt_valid,
    output logic                           deq_valid,
    output logic [PPE_LOG_W-1:0]           deq_in,
    output logic [PPE_LOG_W-1:0]           deq_out,
    output logic [15:0]                    stale_cnt,
    output logic                           err
);
    localparam int N = PPE_WIDTH * PPE_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [N-1:0]     ONE     = {{(N-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0]     cnt      [N];
    logic [CNT_W-1:0]     cnt_next [N];
    logic [N-1:0]         amask, gmask, nz_vec, full_vec, req_next;
    logic                 gnt_take, hit, stale, arr_acc;
    logic [PPE_LOG_W-1:0] gi, gj;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            nz_vec[k]   = (cnt[k] != '0);
            full_vec[k] = (cnt[k] == CNT_MAX);
        end
        amask = '0;
        gi    = '0;
        gj    = '0;
        // Isolate the lowest set grant bit; multi-hot grants resolve to it.
        gmask = Gnt & (~Gnt + ONE);
        for (int i = 0; i < PPE_WIDTH; i++) begin
            for (int j = 0; j < PPE_WIDTH; j++) begin
                amask[i*PPE_WIDTH+j] = (arr_in == PPE_LOG_W'(i)) && (arr_out == PPE_LOG_W'(j));
                if (gmask[i*PPE_WIDTH+j]) begin
                    gi = PPE_LOG_W'(i);
                    gj = PPE_LOG_W'(j);
                end
            end
        end
    end

`ifdef PROT_CHECK_EN
    logic multi, prot_err;
    assign multi    = |(Gnt & (Gnt - ONE));
    assign gnt_take = gnt_valid && (Gnt != '0) && !multi;
    assign prot_err = (gnt_valid && multi) || (!gnt_valid && (Gnt != '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else if (prot_err) err <= 1'b1;
    end
`else
    assign gnt_take = gnt_valid && (Gnt != '0);
    assign err      = 1'b0;
`endif

    // A grant on an empty VOQ is the stale echo of an already-drained request.
    assign hit       = gnt_take && |(gmask & nz_vec);
    assign stale     = gnt_take && !hit;
    assign arr_ready = !(|(amask & full_vec)) || (hit && |(amask & gmask));
    assign arr_acc   = arr_valid && arr_ready;

    always_comb begin
        for (int k = 0; k < N; k++) begin
            cnt_next[k] = cnt[k];
            if (arr_acc && amask[k] && !(hit && gmask[k]))
                cnt_next[k] = cnt[k] + CNT_W'(1);
            else if (hit && gmask[k] && !(arr_acc && amask[k]))
                cnt_next[k] = cnt[k] - CNT_W'(1);
            req_next[k] = (cnt_next[k] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) cnt[k] <= '0;
            Req       <= '0;
            deq_valid <= 1'b0;
            deq_in    <= '0;
            deq_out   <= '0;
            stale_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) cnt[k] <= cnt_next[k];
            Req       <= req_next;
            deq_valid <= hit;
            if (hit) begin
                deq_in  <= gi;
                deq_out <= gj;
            end
            if (stale && stale_cnt != 16'hFFFF)
                stale_cnt <= stale_cnt + 16'd1;
        end
    end
endmodule
